// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: AES-128 round-key scheduler and key store for the cipher core.
// Latency: the ack cycle plus NR expansion cycles; key_ready rises with the last slot write.
// Backpressure: key_load stays pending (no ack) while core_full=1 or expansion is running.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   key_load/ack    load request (hold with key_in stable) and 1-cycle capture pulse
//   key_in          cipher key, FIPS byte 0 at [7:0]
//   key_ready       all NR+1 round keys are valid
//   core_full       core busy; key replacement is held off while set
//   core_addr       round address from the core
//   round_key       {valid, key} for core_addr, combinational
//   nr_out          constant round count for the core
module key_sched_ctrl #(
  parameter int NR     = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [127:0]      key_in,
  output logic              key_ack,
  output logic              key_ready,
  input  logic              core_full,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [128:0]      round_key,
  output logic [3:0]        nr_out
);

  localparam int NK = NR + 1;
  localparam logic [3:0]        NR_CNT  = 4'(NR);
  localparam logic [ADDR_W-1:0] NR_ADDR = ADDR_W'(NR);

  // S-box packed as 256 bytes, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       state_q, state_d;
  logic [127:0] slot_q [NK];
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         key_ready_q, key_ready_d;
  logic         accept;
  logic         exp_we;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic         addr_ok;

  // Byte x sits at bit 8*(255-x)+7 = {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One round of the AES-128 expansion from the previous slot.
  always_comb begin
    logic [31:0] t, w0, w1, w2, w3;
    prev_key = slot_q[cnt_q - 4'd1];
    t  = sub_word({prev_key[103:96], prev_key[127:104]}) ^ {24'h0, rcon_q};
    w0 = prev_key[31:0]   ^ t;
    w1 = prev_key[63:32]  ^ w0;
    w2 = prev_key[95:64]  ^ w1;
    w3 = prev_key[127:96] ^ w2;
    next_key = {w3, w2, w1, w0};
  end

  // A key is never swapped under a busy core or an expansion in flight.
  assign accept = key_load && !core_full && (state_q != EXPAND) && !rst;

  always_comb begin
    state_d     = state_q;
    rcon_d      = rcon_q;
    cnt_d       = cnt_q;
    key_ready_d = key_ready_q;
    exp_we      = 1'b0;
    if (accept) begin
      state_d     = EXPAND;
      rcon_d      = 8'h01;
      cnt_d       = 4'd1;
      key_ready_d = 1'b0;
    end else begin
      case (state_q)
        EXPAND: begin
          exp_we = 1'b1;
          rcon_d = xtime(rcon_q);
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == NR_CNT) begin
            state_d     = READY;
            key_ready_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rcon_q      <= 8'h01;
      cnt_q       <= 4'd0;
      key_ready_q <= 1'b0;
      for (int i = 0; i < NK; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rcon_q      <= rcon_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      if (accept)      slot_q[0]     <= key_in;
      else if (exp_we) slot_q[cnt_q] <= next_key;
    end
  end

  // Out-of-range addresses return an invalid all-zero key so the core stalls.
  assign addr_ok   = (core_addr <= NR_ADDR);
  assign round_key = addr_ok ? {key_ready_q, slot_q[core_addr]} : 129'h0;
  assign key_ack   = accept;
  assign key_ready = key_ready_q;
  assign nr_out    = 4'(NR);

endmodule

// File: tb/tb_key_sched_ctrl.sv
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ack;
  logic         key_ready;
  logic         core_full;
  logic [3:0]   core_addr;
  logic [128:0] round_key;
  logic [3:0]   nr_out;

  key_sched_ctrl #(.NR(10), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_ack(key_ack),
    .key_ready(key_ready), .core_full(core_full), .core_addr(core_addr),
    .round_key(round_key), .nr_out(nr_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0]   addr;
    logic [128:0] exp;
  } vec_t;

  vec_t         tbl [16];
  logic [127:0] fips_rk [11];
  logic [127:0] key_fips, key2, key2_rk10;

  // FIPS-197 listings are byte 0 first; the bus carries byte 0 at [7:0].
  function automatic logic [127:0] brev(input logic [127:0] f);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = f[127-8*i -: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called with key_in/key_load set and an ack expected in the current cycle.
  task automatic accept_and_wait(input string nm);
    int cyc;
    #1;
    chk({nm, "_ack"}, 129'(key_ack), 129'd1);
    cyc = 0;
    do begin
      tick();
      key_load = 1'b0;
      cyc++;
    end while (!key_ready && cyc < 30);
    chk({nm, "_latency"}, 129'(cyc), 129'd11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_fips  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    key2      = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    key2_rk10 = 128'hc5302b4d_8ba707f3_174a94e3_7f1d1113;
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].exp  = (i <= 10) ? {1'b1, brev(fips_rk[i])} : 129'h0;
    end

    rst = 1'b1; key_load = 1'b0; key_in = '0; core_full = 1'b0; core_addr = 4'd0;
    #1;
    chk("reset_ack", 129'(key_ack), 129'd0);
    chk("reset_ready", 129'(key_ready), 129'd0);
    chk("reset_round_key", round_key, 129'h0);
    chk("nr_out", 129'(nr_out), 129'd10);
    tick(); tick();
    rst = 1'b0;
    tick();

    // FIPS key expansion, then every address 0..15 from the table.
    key_in = key_fips; key_load = 1'b1;
    accept_and_wait("fips");
    for (int i = 0; i < 16; i++) begin
      core_addr = tbl[i].addr;
      #1;
      chk($sformatf("fips_addr%0d", i), round_key, tbl[i].exp);
    end
    core_addr = 4'd1; #1;
    chk("spec_addr1", round_key, {1'b1, 128'h05766c2a_3939a323_b12c5488_17fefaa0});
    core_addr = 4'd10; #1;
    chk("spec_addr10", round_key, {1'b1, 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0});

    // Reload from READY with a second key held pending through the expansion.
    tick();
    key_in = key_fips; key_load = 1'b1; #1;
    chk("pend_first_ack", 129'(key_ack), 129'd1);
    tick();
    key_in = key2;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk($sformatf("pend_noack_c%0d", k), 129'(key_ack), 129'd0);
      if (k == 1) chk("pend_valid_cleared", 129'(round_key[128]), 129'd0);
      tick();
    end
    core_addr = 4'd10;
    #1;
    chk("pend_ready", 129'(key_ready), 129'd1);
    chk("pend_rk10_first", round_key, {1'b1, brev(fips_rk[10])});
    accept_and_wait("pend_second");
    core_addr = 4'd10; #1;
    chk("pend_rk10_second", round_key, {1'b1, key2_rk10});

    // core_full holds off a reload; old keys stay valid.
    tick();
    core_full = 1'b1; key_in = key_fips; key_load = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("full_noack_c%0d", k), 129'(key_ack), 129'd0);
      chk($sformatf("full_hold_c%0d", k), round_key, {1'b1, key2_rk10});
      tick();
    end
    core_full = 1'b0;
    #1;
    chk("full_release_ack", 129'(key_ack), 129'd1);
    tick();
    key_load = 1'b0;
    #1;
    chk("full_reexp_ready", 129'(key_ready), 129'd0);
    chk("full_reexp_valid", 129'(round_key[128]), 129'd0);
    for (int k = 0; k < 30 && !key_ready; k++) tick();
    #1;
    chk("full_new_rk10", round_key, {1'b1, brev(fips_rk[10])});

    // Reset mid-expansion aborts and clears everything at once.
    tick();
    key_in = key2; key_load = 1'b1; #1;
    chk("rst_mid_ack", 129'(key_ack), 129'd1);
    tick();
    tick(); tick(); tick();
    core_addr = 4'd0;
    rst = 1'b1;
    #1;
    chk("rst_mid_ack_low", 129'(key_ack), 129'd0);
    chk("rst_mid_ready", 129'(key_ready), 129'd0);
    chk("rst_mid_round_key", round_key, 129'h0);
    key_load = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 129'(key_ready), 129'd0);
    chk("post_rst_slot0", round_key, 129'h0);
    tick();
    key_in = key_fips; key_load = 1'b1;
    accept_and_wait("post_rst");
    core_addr = 4'd1; #1;
    chk("post_rst_addr1", round_key, {1'b1, brev(fips_rk[1])});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
